register_file_sb: RTL
=====================

Name: register_file_sb

Overview:
Parametrised successor to the core's two-read/one-write register file. It provides NUM_READ combinational read ports and two write ports: port A carries ALU writeback and port B carries load writeback. It includes optional same-cycle write-to-read bypass and a per-register busy scoreboard for outstanding multi-cycle loads. It sits in the decode/writeback boundary of the MIPS pipeline, and the hazard unit consumes its busy outputs to generate stalls.

Parameters:
DATA_WIDTH  32  width of each register
ADDR_WIDTH  5  index width; depth = 2**ADDR_WIDTH
NUM_READ  2  number of read ports, legal 1..4
BYPASS  1  1 = same-cycle write data and busy-clear visible on reads; 0 = reads show stored state only

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
read_addr  in  NUM_READ*ADDR_WIDTH  packed read indices; port k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH]
read_data  out  NUM_READ*DATA_WIDTH  packed read data, same packing as read_addr
read_busy  out  NUM_READ  1 = addressed register has an outstanding load
write_enable_a  in  1  ALU writeback enable
write_index_a  in  ADDR_WIDTH  ALU writeback index
write_data_a  in  DATA_WIDTH  ALU writeback data
write_enable_b  in  1  load writeback enable; also clears busy
write_index_b  in  ADDR_WIDTH  load writeback index
write_data_b  in  DATA_WIDTH  load writeback data
reserve_enable  in  1  a load has issued; mark destination busy
reserve_index  in  ADDR_WIDTH  load destination index
busy_count  out  ADDR_WIDTH+1  registered number of busy registers

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. While reset is high, all registers, all busy bits and busy_count are 0. Consequently every read_data is 0 and every read_busy is 0.
- Register 0:
  - Always reads 0 and is never busy.
  - Writes and reserves targeting index 0 are ignored.
- Reads: combinational, zero latency. Read ports are fully independent; any two ports may address the same register.
- Writes: take effect on the rising edge of clk.
  - Port A and port B may write different indices in the same cycle; both land.
  - If both target the same nonzero index, port A data is stored, because the ALU result is the younger instruction.
- Bypass:
  - BYPASS=1: when a read index matches an enabled write index this cycle, read_data returns the incoming data, port A having priority over port B. When it matches write_index_b with write_enable_b high, read_busy for that port is 0 unless a reserve to the same index is also active this cycle.
  - BYPASS=0: new data becomes visible the cycle after the edge.
- Scoreboard, one busy bit per register, evaluated at the clock edge:
  - reserve_enable sets busy[reserve_index].
  - write_enable_b clears busy[write_index_b].
  - Set and clear on the same index in the same cycle: set wins, because a new load has issued.
  - A port A write does not change busy.
  - Reserving an already-busy register leaves it busy.
  - A port B write to a non-busy register is legal; data is written and busy stays 0.
- busy_count:
  - Updated on the same edge as the busy bits.
  - Equals the popcount of the busy bits after that edge.
  - Never exceeds 2**ADDR_WIDTH-1.
- Reset mid-operation: asserting reset at any time, including between clock edges, immediately clears all contents and all busy state. Reserves in flight are discarded. A load writeback arriving after reset deassertion writes its data but has no busy bit to clear.
- Out-of-range NUM_READ: values outside 1..4 are a compile-time error and must be rejected by an elaboration check.

Test Plan:
- Reset, then read indices 0,5 → read_data 0,0 and read_busy 0,0. Pulse reset mid-cycle after writing r5=7 → r5 reads 0 immediately.
- Port A writes r1=3, then r2=10. Read (1,2) → 3,10. Write r2=5 with write_enable_a=0 → r2 still 10. Write r0=0xFFFF → r0 reads 0.
- BYPASS=1: in the same cycle write_enable_a, index 4, data 0x55, with read_addr port0=4 → read_data 0x55 before the edge. BYPASS=0 → old value before the edge, 0x55 after.
- Simultaneous writes: port A r6=1, port B r6=2 → r6=1. Port A r7=8 with port B r8=9 → r7=8, r8=9.
- Scoreboard: reserve r3 → read_busy 1, busy_count 1. Reserve r9 → busy_count 2. Port B writes r3=0x1234 → r3 not busy, data 0x1234, busy_count 1. Reserve r9 and port B r9 in the same cycle → r9 stays busy, busy_count 1.
- NUM_READ=4: all four ports read r1,r1,r2,r0 with r1=3 and r2=10 → 3,3,10,0. Reserve r0 → busy_count unchanged.

Source files
------------

// File: rtl/register_file_sb_if.sv
// -----------------------------------------------------------------------------
// register_file_sb_if
// Bus bundle for the register file with load scoreboard.
//   read_addr/read_data/read_busy : NUM_READ packed combinational read ports
//   write_*_a                     : ALU writeback port
//   write_*_b                     : load writeback port (also clears busy)
//   reserve_*                     : load issue, marks destination busy
//   busy_count                    : registered popcount of busy bits
// master = pipeline side driving requests, slave = register file.
// -----------------------------------------------------------------------------
interface register_file_sb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2
);
    logic [NUM_READ*ADDR_WIDTH-1:0] read_addr;
    logic [NUM_READ*DATA_WIDTH-1:0] read_data;
    logic [NUM_READ-1:0]            read_busy;
    logic                           write_enable_a;
    logic [ADDR_WIDTH-1:0]          write_index_a;
    logic [DATA_WIDTH-1:0]          write_data_a;
    logic                           write_enable_b;
    logic [ADDR_WIDTH-1:0]          write_index_b;
    logic [DATA_WIDTH-1:0]          write_data_b;
    logic                           reserve_enable;
    logic [ADDR_WIDTH-1:0]          reserve_index;
    logic [ADDR_WIDTH:0]            busy_count;

    modport master (
        output read_addr, write_enable_a, write_index_a, write_data_a,
               write_enable_b, write_index_b, write_data_b,
               reserve_enable, reserve_index,
        input  read_data, read_busy, busy_count
    );

    modport slave (
        input  read_addr, write_enable_a, write_index_a, write_data_a,
               write_enable_b, write_index_b, write_data_b,
               reserve_enable, reserve_index,
        output read_data, read_busy, busy_count
    );
endinterface

// File: rtl/register_file_sb.sv
// -----------------------------------------------------------------------------
// register_file_sb
// Multi-read, dual-write register file with a per-register busy scoreboard
// for outstanding loads.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, clears data, busy bits and count
//   bus   : register_file_sb_if.slave (read ports, ALU/load writeback,
//           load reserve, busy_count)
// Register 0 is hardwired to zero and is never busy. With BYPASS=1 reads see
// same-cycle write data (port A over port B) and same-cycle busy clears.
// -----------------------------------------------------------------------------
module register_file_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    register_file_sb_if.slave    bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = {ADDR_WIDTH{1'b0}};

    // Elaboration guard on the read port count
    generate
        if (NUM_READ < 1 || NUM_READ > 4) begin : g_bad_num_read
            $error("register_file_sb: NUM_READ must be in 1..4");
        end
    endgenerate

    // Number of set bits in a busy vector
    function automatic logic [ADDR_WIDTH:0] popcount(input logic [DEPTH-1:0] vec);
        logic [ADDR_WIDTH:0] cnt;
        cnt = {(ADDR_WIDTH+1){1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + {{ADDR_WIDTH{1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

    logic [DATA_WIDTH-1:0]          regs_r [DEPTH];
    logic [DEPTH-1:0]               busy_r;
    logic [DEPTH-1:0]               busy_next_s;
    logic [ADDR_WIDTH:0]            busy_count_r;
    logic [NUM_READ*DATA_WIDTH-1:0] rd_data_s;
    logic [NUM_READ-1:0]            rd_busy_s;
    logic [ADDR_WIDTH-1:0]          rd_addr_s;

    wire wr_a_s = bus.write_enable_a && (bus.write_index_a != ZERO_IDX);
    wire wr_b_s = bus.write_enable_b && (bus.write_index_b != ZERO_IDX);

    // Next busy state: a reserve sets (and beats a same-index clear), load writeback clears
    always_comb begin
        busy_next_s = {DEPTH{1'b0}};
        for (int i = 1; i < DEPTH; i++) begin
            busy_next_s[i] = (bus.reserve_enable && (bus.reserve_index == ADDR_WIDTH'(i))) ||
                             (busy_r[i] && !(bus.write_enable_b &&
                                             (bus.write_index_b == ADDR_WIDTH'(i))));
        end
    end

    // Register storage; port A written last so it wins a same-index collision
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            if (wr_b_s) begin
                regs_r[bus.write_index_b] <= bus.write_data_b;
            end
            if (wr_a_s) begin
                regs_r[bus.write_index_a] <= bus.write_data_a;
            end
        end
    end

    // Scoreboard bits and their registered population count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r       <= {DEPTH{1'b0}};
            busy_count_r <= {(ADDR_WIDTH+1){1'b0}};
        end else begin
            busy_r       <= busy_next_s;
            busy_count_r <= popcount(busy_next_s);
        end
    end

    // Combinational read ports with optional same-cycle bypass; reset forces zeros
    always_comb begin
        rd_data_s = {(NUM_READ*DATA_WIDTH){1'b0}};
        rd_busy_s = {NUM_READ{1'b0}};
        rd_addr_s = ZERO_IDX;
        for (int k = 0; k < NUM_READ; k++) begin
            rd_addr_s = bus.read_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

            if (reset || (rd_addr_s == ZERO_IDX)) begin
                rd_data_s[k*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
            end else if (BYPASS && bus.write_enable_a && (bus.write_index_a == rd_addr_s)) begin
                rd_data_s[k*DATA_WIDTH +: DATA_WIDTH] = bus.write_data_a;
            end else if (BYPASS && bus.write_enable_b && (bus.write_index_b == rd_addr_s)) begin
                rd_data_s[k*DATA_WIDTH +: DATA_WIDTH] = bus.write_data_b;
            end else begin
                rd_data_s[k*DATA_WIDTH +: DATA_WIDTH] = regs_r[rd_addr_s];
            end

            // A same-cycle load writeback hides busy unless a new reserve re-arms it
            if (reset || (rd_addr_s == ZERO_IDX)) begin
                rd_busy_s[k] = 1'b0;
            end else if (BYPASS && bus.write_enable_b && (bus.write_index_b == rd_addr_s)) begin
                rd_busy_s[k] = bus.reserve_enable && (bus.reserve_index == rd_addr_s);
            end else begin
                rd_busy_s[k] = busy_r[rd_addr_s];
            end
        end
    end

    assign bus.read_data  = rd_data_s;
    assign bus.read_busy  = rd_busy_s;
    assign bus.busy_count = busy_count_r;

endmodule
